// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the optical pulse sequencer and its start path.
package pulse_seq_pkg;

  localparam int unsigned PS_CNT_W = 32;
  localparam int unsigned PS_NUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4,
    ST_REL   = 3'd5
  } ps_state_e;

  // Cycles from trigger to the done strobe, using the same width/period
  // normalisation as the sequencer. Lets the start path size its lockout.
  function automatic logic [63:0] ps_burst_len(
    input logic [PS_CNT_W-1:0] delay,
    input logic [PS_CNT_W-1:0] width,
    input logic [PS_CNT_W-1:0] period,
    input logic [PS_NUM_W-1:0] count
  );
    logic [63:0] w;
    logic [63:0] p;
    w = (width == '0) ? 64'd1 : 64'(width);
    p = (64'(period) > w) ? 64'(period) : (w + 64'd1);
    if (count == '0) begin
      ps_burst_len = 64'd2;
    end else begin
      ps_burst_len = 64'(delay) + 64'd1 + ((64'(count) - 64'd1) * p) + w + 64'd1;
    end
  endfunction

endpackage

// File: rtl/ps_edge_det.sv
// Registered rising-edge detector. The previous-value flop presets to 1 so a
// level already high when reset releases is not seen as a new edge.
module ps_edge_det
  import pulse_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the previous-sample flop is simply the current input.
  always_comb begin
    prev_d = d;
  end

  // Previous-sample register with preset-high synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Burst generator for optical synchronizing pulses: programmable delay,
// width, period and count, with lockout until the start line is released.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = PS_CNT_W,
  parameter int unsigned NUM_W = PS_NUM_W
) (
  input  logic             ps_clk,
  input  logic             ps_rst_n,
  input  logic             ps_start,
  input  logic [CNT_W-1:0] ps_delay,
  input  logic [CNT_W-1:0] ps_width,
  input  logic [CNT_W-1:0] ps_period,
  input  logic [NUM_W-1:0] ps_count,
  output logic             ps_out,
  output logic             ps_busy,
  output logic             ps_done,
  output logic             ps_ready
);

  ps_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] wm1_q, wm1_d;
  logic [CNT_W-1:0] lowm1_q, lowm1_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             start_rise;
  logic             trig;
  logic [CNT_W-1:0] w_n, w_p1, p_n, low_n;

  ps_edge_det u_edge (
    .clk   (ps_clk),
    .rst_n (ps_rst_n),
    .d     (ps_start),
    .rise  (start_rise)
  );

  assign trig = start_rise & (state_q == ST_IDLE);

  // Width/period normalisation of the live config; only used at the trigger.
  // w+1 saturates, in which case the low phase is held at one cycle.
  always_comb begin
    w_n   = (ps_width == '0) ? CNT_W'(1) : ps_width;
    w_p1  = (w_n == '1) ? w_n : (w_n + CNT_W'(1));
    p_n   = (ps_period > w_n) ? ps_period : w_p1;
    low_n = p_n - w_n;
  end

  // Next-state and registered-output computation for the burst FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dly_d   = dly_q;
    wm1_d   = wm1_q;
    lowm1_d = lowm1_q;
    out_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (trig) begin
          dly_d   = ps_delay;
          wm1_d   = w_n - CNT_W'(1);
          lowm1_d = (low_n == '0) ? '0 : (low_n - CNT_W'(1));
          rem_d   = ps_count;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (ps_count == '0) ? ST_DONE : ST_DELAY;
        end else begin
          ready_d = ~ps_start;
        end
      end
      ST_DELAY: begin
        if (cnt_q == dly_q) begin
          cnt_d   = '0;
          out_d   = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        out_d = 1'b1;
        if (cnt_q == wm1_q) begin
          cnt_d = '0;
          out_d = 1'b0;
          if (rem_q == NUM_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_q - NUM_W'(1);
            state_d = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == lowm1_q) begin
          cnt_d   = '0;
          out_d   = 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // An empty burst enters here with busy still set and no strobe yet;
        // it spends one more cycle here to emit the strobe.
        if (done_q) begin
          state_d = ST_REL;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      ST_REL: begin
        busy_d = 1'b0;
        if (!ps_start) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REL;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge ps_clk) begin
    if (!ps_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dly_q   <= '0;
      wm1_q   <= '0;
      lowm1_q <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dly_q   <= dly_d;
      wm1_q   <= wm1_d;
      lowm1_q <= lowm1_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ps_out   = out_q;
  assign ps_busy  = busy_q;
  assign ps_done  = done_q;
  assign ps_ready = ready_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: a waveform-level reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_pulse_sequencer;

  logic        clk = 1'b0;
  logic        ps_rst_n = 1'b0;
  logic        ps_start = 1'b0;
  logic [31:0] ps_delay = 32'd0;
  logic [31:0] ps_width = 32'd0;
  logic [31:0] ps_period = 32'd0;
  logic [7:0]  ps_count = 8'd0;
  logic        ps_out, ps_busy, ps_done, ps_ready;

  int checks = 0;
  int errors = 0;

  pulse_sequencer dut (
    .ps_clk    (clk),
    .ps_rst_n  (ps_rst_n),
    .ps_start  (ps_start),
    .ps_delay  (ps_delay),
    .ps_width  (ps_width),
    .ps_period (ps_period),
    .ps_count  (ps_count),
    .ps_out    (ps_out),
    .ps_busy   (ps_busy),
    .ps_done   (ps_done),
    .ps_ready  (ps_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a burst triggered in cycle T with normalised w, p and
  // length L drives out high where k = r-(delay+2) lies in a pulse window,
  // busy for 1 <= r < L, done at r == L, then waits for start to drop.
  longint cyc = 0;
  bit     m_in = 1'b0;
  bit     m_rst_prev = 1'b1;
  bit     m_prev_start = 1'b1;
  longint m_t, m_len, m_d, m_w, m_p, m_c;
  longint r_m, k_m;
  logic   eo, eb, ed, er;

  always @(negedge clk) begin
    eo = 1'b0; eb = 1'b0; ed = 1'b0; er = 1'b0;
    if (!m_rst_prev) begin
      if (m_in) begin
        r_m = cyc - m_t;
        eb  = (r_m >= 1) && (r_m < m_len);
        ed  = (r_m == m_len);
        if (m_c != 0) begin
          k_m = r_m - (m_d + 2);
          eo  = (k_m >= 0) && (k_m < ((m_c - 1) * m_p + m_w)) && ((k_m % m_p) < m_w);
        end
      end else begin
        er = !m_prev_start;
      end
    end
    chk($sformatf("model_out@%0d", cyc), ps_out, eo);
    chk($sformatf("model_busy@%0d", cyc), ps_busy, eb);
    chk($sformatf("model_done@%0d", cyc), ps_done, ed);
    chk($sformatf("model_ready@%0d", cyc), ps_ready, er);
    if (!ps_rst_n) begin
      m_in = 1'b0;
      m_rst_prev = 1'b1;
      m_prev_start = 1'b1;
    end else begin
      m_rst_prev = 1'b0;
      if (!m_in && ps_start && !m_prev_start) begin
        m_in  = 1'b1;
        m_t   = cyc;
        m_d   = longint'(ps_delay);
        m_w   = (ps_width == 32'd0) ? 1 : longint'(ps_width);
        m_p   = (longint'(ps_period) > m_w) ? longint'(ps_period) : m_w + 1;
        m_c   = longint'(ps_count);
        m_len = (m_c == 0) ? 2 : (m_d + 1 + (m_c - 1) * m_p + m_w + 1);
      end else if (m_in && (cyc >= m_t + m_len + 1) && !ps_start) begin
        m_in = 1'b0;
      end
      m_prev_start = ps_start;
    end
    cyc++;
  end

  // Per-scenario record of DUT outputs, indexed by cycles after the trigger.
  logic o_h [0:1099];
  logic b_h [0:1099];
  logic d_h [0:1099];
  logic y_h [0:1099];

  task automatic run(input int hold, input int n, input int rst_r,
                     input int chg_r, input logic [31:0] chg_w);
    @(posedge clk); #2;
    ps_start = 1'b1;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      o_h[r] = ps_out; b_h[r] = ps_busy; d_h[r] = ps_done; y_h[r] = ps_ready;
      @(posedge clk); #2;
      ps_start = (r + 1 < hold);
      ps_rst_n = (r + 1 != rst_r);
      if (r + 1 == chg_r) ps_width = chg_w;
    end
  endtask

  int ndone;

  initial begin
    // Reset with start low, then release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", ps_out, 1'b0);
    chk("rst_busy", ps_busy, 1'b0);
    chk("rst_done", ps_done, 1'b0);
    chk("rst_ready", ps_ready, 1'b0);
    @(posedge clk); #2;
    ps_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", ps_ready, 1'b1);
    @(posedge clk); #2;

    // Basic burst: delay 3, width 2, period 5, count 3.
    ps_delay = 32'd3; ps_width = 32'd2; ps_period = 32'd5; ps_count = 8'd3;
    run(1, 25, -1, -1, 32'd0);
    chk("t1_busy0", b_h[0], 1'b0);
    chk("t1_busy1", b_h[1], 1'b1);
    chk("t1_out4", o_h[4], 1'b0);
    chk("t1_out5", o_h[5], 1'b1);
    chk("t1_out6", o_h[6], 1'b1);
    chk("t1_out7", o_h[7], 1'b0);
    chk("t1_out10", o_h[10], 1'b1);
    chk("t1_out16", o_h[16], 1'b1);
    chk("t1_busy16", b_h[16], 1'b1);
    chk("t1_busy17", b_h[17], 1'b0);
    chk("t1_done16", d_h[16], 1'b0);
    chk("t1_done17", d_h[17], 1'b1);
    chk("t1_out17", o_h[17], 1'b0);

    // Start held 1000 cycles across a 20-cycle burst.
    ps_delay = 32'd3; ps_width = 32'd3; ps_period = 32'd6; ps_count = 8'd3;
    run(1000, 1010, -1, -1, 32'd0);
    ndone = 0;
    for (int r = 0; r < 1010; r++) ndone += int'(d_h[r]);
    chk_int("t2_done_count", ndone, 1);
    chk("t2_done20", d_h[20], 1'b1);
    chk("t2_ready999", y_h[999], 1'b0);
    chk("t2_ready1001", y_h[1001], 1'b1);

    // Zero width/period: 1-cycle pulses 2 cycles apart.
    ps_delay = 32'd0; ps_width = 32'd0; ps_period = 32'd0; ps_count = 8'd2;
    run(1, 10, -1, -1, 32'd0);
    chk("t3_out1", o_h[1], 1'b0);
    chk("t3_out2", o_h[2], 1'b1);
    chk("t3_out3", o_h[3], 1'b0);
    chk("t3_out4", o_h[4], 1'b1);
    chk("t3_done5", d_h[5], 1'b1);

    // Empty burst.
    ps_delay = 32'd5; ps_width = 32'd2; ps_period = 32'd5; ps_count = 8'd0;
    run(1, 10, -1, -1, 32'd0);
    ndone = 0;
    for (int r = 0; r < 10; r++) ndone += int'(o_h[r]);
    chk_int("t4_out_count", ndone, 0);
    chk("t4_busy1", b_h[1], 1'b1);
    chk("t4_busy2", b_h[2], 1'b0);
    chk("t4_done2", d_h[2], 1'b1);

    // Reset during the second pulse while start is held high.
    ps_delay = 32'd1; ps_width = 32'd4; ps_period = 32'd8; ps_count = 8'd3;
    run(200, 210, 12, -1, 32'd0);
    chk("t5_out12", o_h[12], 1'b1);
    chk("t5_out13", o_h[13], 1'b0);
    chk("t5_busy13", b_h[13], 1'b0);
    chk("t5_busy100", b_h[100], 1'b0);
    chk("t5_ready150", y_h[150], 1'b0);
    chk("t5_ready201", y_h[201], 1'b1);

    // Width changed 2 -> 9 mid-burst; next burst uses 9 (period 5 -> 10).
    ps_delay = 32'd0; ps_width = 32'd2; ps_period = 32'd5; ps_count = 8'd3;
    run(1, 25, -1, 3, 32'd9);
    chk("t6_busy1", b_h[1], 1'b1);
    chk("t6_out3", o_h[3], 1'b1);
    chk("t6_out4", o_h[4], 1'b0);
    chk("t6_out8", o_h[8], 1'b1);
    chk("t6_out9", o_h[9], 1'b0);
    chk("t6_done14", d_h[14], 1'b1);
    ps_count = 8'd2;
    run(1, 30, -1, -1, 32'd0);
    chk("t7_out10", o_h[10], 1'b1);
    chk("t7_out11", o_h[11], 1'b0);
    chk("t7_out12", o_h[12], 1'b1);
    chk("t7_done21", d_h[21], 1'b1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Receiving end of the start-request line: consumes the level start request driven by the start/anti-bounce block and generates a burst of optical synchronizing pulses with programmable delay, width, period and count. The block locks out further start requests until the whole burst has finished and the request line has been released. It supplies the "generation in progress" status that the start path uses for lockout.

## Interface
Parameters:
- CNT_W, 32, width of the delay/width/period counters and config inputs
- NUM_W, 8, width of the pulse-count input

Ports:
- ps_clk  in  1  system clock; all logic on its rising edge
- ps_rst_n  in  1  synchronous, active-low reset
- ps_start  in  1  start request, active high, same clock domain; may stay high for up to 2×10^8 cycles
- ps_delay  in  CNT_W  cycles from trigger to first pulse rising edge, minus 1
- ps_width  in  CNT_W  high time in cycles; 0 is treated as 1
- ps_period  in  CNT_W  rising-to-rising period in cycles; values ≤ width are forced to width+1
- ps_count  in  NUM_W  number of pulses in the burst; 0 means an empty burst
- ps_out  out  1  optical pulse drive, active high
- ps_busy  out  1  high from trigger until the last pulse falls
- ps_done  out  1  one-cycle strobe at burst end
- ps_ready  out  1  high when idle and re-armed (ps_start low)

## Operation
- Edge detect: register start_q <= ps_start. Trigger = ps_start & ~start_q & state==IDLE.
- Config latch: delay, width, period and count are captured on the trigger edge. Later changes have no effect until the next burst.
- Normalisation at latch:
  - w = max(ps_width, 1)
  - p = (ps_period > w) ? ps_period : w+1
  - low time = p − w
- States:
  - IDLE: ps_ready = ~ps_start. On trigger: if count==0, go to DONE; else go to DELAY with cnt=0.
  - DELAY: count delay cycles. When cnt==delay, go to HIGH with cnt=0.
  - HIGH: ps_out=1. When cnt==w−1: decrement remaining; if remaining==1 go to DONE, else go to LOW.
  - LOW: ps_out=0. When cnt==p−w−1, go to HIGH.
  - DONE: ps_done=1 for exactly one cycle, busy=0, then go to REL.
  - REL: wait for ps_start==0, then go to IDLE. A new trigger needs a fresh 0→1 on ps_start.
- Start activity while in DELAY/HIGH/LOW/DONE/REL is ignored.
- Counter arithmetic is unsigned CNT_W. The w+1 computation saturates at all-ones; no wrap.
- Reset (any state, including mid-pulse): next cycle state=IDLE, ps_out=0, ps_busy=0, ps_done=0, ps_ready=0, start_q=1. Forcing start_q=1 means a request held high through reset does not fire.

## Timing
- Reset values: ps_out=0, ps_busy=0, ps_done=0, ps_ready=0.
- Trigger edge at cycle T:
  - ps_busy=1 from T+1.
  - First ps_out rise at T+1+delay+1, i.e. delay=0 gives ps_out high at T+2.
- Each pulse is high exactly w cycles; rising edges are spaced exactly p cycles apart.
- Last falling edge at cycle E:
  - ps_done=1 and ps_busy=0 during cycle E (registered together with the ps_out fall).
  - ps_ready may assert no earlier than E+2.
- count==0: ps_busy high for one cycle (T+1), ps_done at T+2, ps_out stays 0.
- Total burst length, trigger to done = delay + 1 + (count−1)·p + w + 1 cycles.

## Structure
- Shared package pulse_seq_pkg holds:
  - state enum (IDLE, DELAY, HIGH, LOW, DONE, REL)
  - default CNT_W/NUM_W constants
  - burst-length function for reuse by the start-path lockout
- One sub-module is natural: ps_edge_det, the registered rising-edge detector with a reset-preset previous value.
- Remainder: a single FSM plus one shared down-counter/up-counter in the top module.

## Test plan
- delay=3, width=2, period=5, count=3, single ps_start pulse → ps_out high at T+5..T+6, T+10..T+11, T+15..T+16; ps_done at T+17; ps_busy T+1..T+16.
- ps_start held high for 1000 cycles across a 20-cycle burst → exactly one burst; ps_ready stays 0 until ps_start falls; a second 0→1 starts a new burst.
- width=0, period=0, count=2, delay=0 → 1-cycle pulses 2 cycles apart (ps_out at T+2 and T+4); done at T+5.
- count=0 → no ps_out activity; ps_busy only at T+1; ps_done at T+2.
- ps_rst_n low during HIGH of pulse 2 while ps_start is high → ps_out=0 next cycle; no new burst until ps_start goes 0 then 1.
- Change ps_width mid-burst (2→9) → the current burst keeps width 2; the next burst uses 9.
